// File: rtl/axis_store_memory.sv
// Word store fed by an AXI-Stream slave; replays the stored batch in write order on an
// AXI-Stream master when rd_start is pulsed, then empties itself for the next batch.
module axis_store_memory #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                    s01_axis_aclk,
    input  logic                    s01_axis_aresetn,
    input  logic [DATA_WIDTH-1:0]   s01_axis_tdata,
    input  logic [DATA_WIDTH/8-1:0] s01_axis_tstrb,
    input  logic                    s01_axis_tvalid,
    input  logic                    s01_axis_tlast,
    output logic                    s01_axis_tready,
    input  logic                    m01_axis_tready,
    output logic [DATA_WIDTH-1:0]   m01_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m01_axis_tstrb,
    output logic                    m01_axis_tvalid,
    output logic                    m01_axis_tlast,
    input  logic                    rd_start,
    output logic [ADDR_WIDTH:0]     wr_count,
    output logic                    full,
    output logic                    busy
);

    localparam int unsigned Depth = 2 ** ADDR_WIDTH;
    localparam int unsigned StrbWidth = DATA_WIDTH / 8;
    localparam logic [ADDR_WIDTH:0] DepthCount = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [ADDR_WIDTH:0] OneCount = {{ADDR_WIDTH{1'b0}}, 1'b1};

    typedef enum logic [0:0] {StIdle, StRead} state_e;

    state_e                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0]  rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]    wr_count_q, wr_count_d;
    logic [DATA_WIDTH-1:0]  m_tdata_q, m_tdata_d;
    logic [StrbWidth-1:0]   m_tstrb_q, m_tstrb_d;
    logic                   m_tvalid_q, m_tvalid_d;
    logic                   m_tlast_q, m_tlast_d;
    // Keeps tready low while reset is held and for the first cycle after release.
    logic                   ready_en_q;

    logic [DATA_WIDTH-1:0]  mem [Depth];
    logic [DATA_WIDTH-1:0]  wr_data_masked;
    logic                   wr_store;
    logic [ADDR_WIDTH:0]    count_after;
    logic [ADDR_WIDTH-1:0]  rd_ptr_next;

    // Unused by storage; tlast from upstream carries no meaning here.
    logic unused_tlast;
    assign unused_tlast = s01_axis_tlast;

    assign full            = (wr_count_q == DepthCount);
    assign busy            = (state_q == StRead);
    assign s01_axis_tready = ready_en_q && (state_q == StIdle) && !full;
    assign wr_store        = s01_axis_tvalid && s01_axis_tready && (|s01_axis_tstrb);
    assign count_after     = wr_count_q + {{ADDR_WIDTH{1'b0}}, wr_store};
    assign rd_ptr_next     = rd_ptr_q + 1'b1;

    assign wr_count        = wr_count_q;
    assign m01_axis_tdata  = m_tdata_q;
    assign m01_axis_tstrb  = m_tstrb_q;
    assign m01_axis_tvalid = m_tvalid_q;
    assign m01_axis_tlast  = m_tlast_q;

    // Zero every byte whose strobe is clear.
    always_comb begin
        wr_data_masked = '0;
        for (int i = 0; i < StrbWidth; i++) begin
            if (s01_axis_tstrb[i]) begin
                wr_data_masked[i*8 +: 8] = s01_axis_tdata[i*8 +: 8];
            end
        end
    end

    // Storage array; deliberately not reset.
    always_ff @(posedge s01_axis_aclk) begin
        if (wr_store) begin
            mem[wr_ptr_q] <= wr_data_masked;
        end
    end

    // Next-state logic for write pointer/count, replay pointer and master output registers.
    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        wr_count_d = wr_count_q;
        m_tdata_d  = m_tdata_q;
        m_tstrb_d  = m_tstrb_q;
        m_tvalid_d = m_tvalid_q;
        m_tlast_d  = m_tlast_q;
        unique case (state_q)
            StIdle: begin
                if (wr_store) begin
                    wr_ptr_d   = wr_ptr_q + 1'b1;
                    wr_count_d = count_after;
                end
                if (rd_start && (count_after != '0)) begin
                    state_d    = StRead;
                    rd_ptr_d   = '0;
                    // A word written this very cycle to slot 0 is not yet in the array.
                    m_tdata_d  = (wr_store && (wr_ptr_q == '0)) ? wr_data_masked : mem[0];
                    m_tvalid_d = 1'b1;
                    m_tstrb_d  = '1;
                    m_tlast_d  = (count_after == OneCount);
                end
            end
            StRead: begin
                if (m01_axis_tready && m_tvalid_q) begin
                    if (m_tlast_q) begin
                        state_d    = StIdle;
                        wr_ptr_d   = '0;
                        rd_ptr_d   = '0;
                        wr_count_d = '0;
                        m_tdata_d  = '0;
                        m_tstrb_d  = '0;
                        m_tvalid_d = 1'b0;
                        m_tlast_d  = 1'b0;
                    end else begin
                        rd_ptr_d  = rd_ptr_next;
                        m_tdata_d = mem[rd_ptr_next];
                        m_tlast_d = ({1'b0, rd_ptr_next} == (wr_count_q - 1'b1));
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and output registers; async reset aborts any replay in progress.
    always_ff @(posedge s01_axis_aclk or negedge s01_axis_aresetn) begin
        if (!s01_axis_aresetn) begin
            state_q    <= StIdle;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            wr_count_q <= '0;
            m_tdata_q  <= '0;
            m_tstrb_q  <= '0;
            m_tvalid_q <= 1'b0;
            m_tlast_q  <= 1'b0;
            ready_en_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_count_q <= wr_count_d;
            m_tdata_q  <= m_tdata_d;
            m_tstrb_q  <= m_tstrb_d;
            m_tvalid_q <= m_tvalid_d;
            m_tlast_q  <= m_tlast_d;
            ready_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_axis_store_memory.sv
// Directed-plus-random bench for axis_store_memory with a queue-based reference model.
module tb_axis_store_memory;

    logic        clk;
    logic        rst_n;
    logic [31:0] s_tdata;
    logic [3:0]  s_tstrb;
    logic        s_tvalid;
    logic        s_tlast;
    logic        s_tready;
    logic        m_tready;
    logic [31:0] m_tdata;
    logic [3:0]  m_tstrb;
    logic        m_tvalid;
    logic        m_tlast;
    logic        rd_start;
    logic [4:0]  wr_count;
    logic        full;
    logic        busy;

    int errors = 0;
    int checks = 0;
    logic [31:0] model_q[$];

    axis_store_memory #(
        .DATA_WIDTH(32),
        .ADDR_WIDTH(4)
    ) dut (
        .s01_axis_aclk   (clk),
        .s01_axis_aresetn(rst_n),
        .s01_axis_tdata  (s_tdata),
        .s01_axis_tstrb  (s_tstrb),
        .s01_axis_tvalid (s_tvalid),
        .s01_axis_tlast  (s_tlast),
        .s01_axis_tready (s_tready),
        .m01_axis_tready (m_tready),
        .m01_axis_tdata  (m_tdata),
        .m01_axis_tstrb  (m_tstrb),
        .m01_axis_tvalid (m_tvalid),
        .m01_axis_tlast  (m_tlast),
        .rd_start        (rd_start),
        .wr_count        (wr_count),
        .full            (full),
        .busy            (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mask(input logic [31:0] d, input logic [3:0] s);
        logic [31:0] r;
        r = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (s[i]) r[i*8 +: 8] = d[i*8 +: 8];
        end
        return r;
    endfunction

    // mode 0: sink always ready; 1: random stalls; 2: stall the first three cycles
    task automatic replay(input bit pulse, input int mode);
        int n;
        int idx;
        int cyc;
        n = model_q.size();
        idx = 0;
        cyc = 0;
        if (pulse) begin
            rd_start = 1'b1;
            tick();
            rd_start = 1'b0;
        end
        while (idx < n && cyc < 400) begin
            case (mode)
                0: m_tready = 1'b1;
                1: m_tready = 1'($urandom_range(0, 1));
                default: m_tready = (cyc >= 3);
            endcase
            chk("m_tvalid", {31'b0, m_tvalid}, 32'd1);
            chk("m_tdata", m_tdata, model_q[idx]);
            chk("m_tlast", {31'b0, m_tlast}, (idx == n - 1) ? 32'd1 : 32'd0);
            chk("m_tstrb", {28'b0, m_tstrb}, 32'hF);
            chk("busy_rd", {31'b0, busy}, 32'd1);
            chk("s_tready_rd", {31'b0, s_tready}, 32'd0);
            if (m_tready) idx++;
            tick();
            cyc++;
        end
        chk("replay_words", idx, n);
        m_tready = 1'b0;
        chk("post_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("post_tlast", {31'b0, m_tlast}, 32'd0);
        chk("post_tdata", m_tdata, 32'd0);
        chk("post_count", {27'b0, wr_count}, 32'd0);
        chk("post_busy", {31'b0, busy}, 32'd0);
        chk("post_tready", {31'b0, s_tready}, 32'd1);
        model_q.delete();
    endtask

    task automatic write_beat(input logic [31:0] d, input logic [3:0] s, input bit rd);
        bit exp_rdy;
        exp_rdy = (model_q.size() < 16);
        s_tdata  = d;
        s_tstrb  = s;
        s_tvalid = 1'b1;
        s_tlast  = 1'($urandom_range(0, 1));
        rd_start = rd;
        chk("s_tready", {31'b0, s_tready}, {31'b0, exp_rdy});
        tick();
        s_tvalid = 1'b0;
        rd_start = 1'b0;
        if (exp_rdy && s != 4'h0) model_q.push_back(mask(d, s));
        if (!rd) chk("wr_count", {27'b0, wr_count}, model_q.size());
    endtask

    initial begin
        rst_n = 1'b0;
        s_tdata = '0;
        s_tstrb = '0;
        s_tvalid = 1'b0;
        s_tlast = 1'b0;
        m_tready = 1'b0;
        rd_start = 1'b0;

        // Reset state
        #12;
        chk("rst_tready", {31'b0, s_tready}, 32'd0);
        chk("rst_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("rst_tlast", {31'b0, m_tlast}, 32'd0);
        chk("rst_tdata", m_tdata, 32'd0);
        chk("rst_count", {27'b0, wr_count}, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_full", {31'b0, full}, 32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("rel_tready", {31'b0, s_tready}, 32'd1);

        // Three words, sink always ready
        write_beat(32'hA, 4'hF, 1'b0);
        write_beat(32'hB, 4'hF, 1'b0);
        write_beat(32'hC, 4'hF, 1'b0);
        replay(1'b1, 0);

        // Fill to depth; a 17th beat must be held off
        for (int i = 0; i < 16; i++) write_beat($urandom, 4'hF, 1'b0);
        chk("full", {31'b0, full}, 32'd1);
        chk("full_tready", {31'b0, s_tready}, 32'd0);
        s_tdata = 32'hDEAD_BEEF;
        s_tstrb = 4'hF;
        s_tvalid = 1'b1;
        tick();
        chk("held_tready", {31'b0, s_tready}, 32'd0);
        chk("held_count", {27'b0, wr_count}, 32'd16);
        s_tvalid = 1'b0;
        replay(1'b1, 1);

        // Backpressure for three cycles on a two-word batch
        write_beat($urandom, 4'hF, 1'b0);
        write_beat($urandom, 4'hF, 1'b0);
        replay(1'b1, 2);

        // Partial strobes and an all-zero strobe beat
        write_beat(32'h1234_5678, 4'b0011, 1'b0);
        write_beat(32'hCAFE_F00D, 4'b0000, 1'b0);
        chk("strb_count", {27'b0, wr_count}, 32'd1);
        chk("strb_model", model_q[0], 32'h0000_5678);
        replay(1'b1, 0);

        // Random batches with random strobes and random backpressure
        for (int r = 0; r < 5; r++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int i = 0; i < n; i++) begin
                logic [3:0] s;
                s = ($urandom_range(0, 5) == 0) ? 4'h0 : 4'($urandom);
                write_beat($urandom, s, 1'b0);
            end
            if (model_q.size() == 0) write_beat($urandom, 4'hF, 1'b0);
            replay(1'b1, 1);
        end

        // rd_start while empty is ignored
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("empty_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("empty_busy", {31'b0, busy}, 32'd0);
        tick();
        chk("empty_tvalid2", {31'b0, m_tvalid}, 32'd0);

        // Reset in the middle of a replay
        for (int i = 0; i < 3; i++) write_beat($urandom, 4'hF, 1'b0);
        rd_start = 1'b1;
        tick();
        rd_start = 1'b0;
        chk("pre_rst_tvalid", {31'b0, m_tvalid}, 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_tvalid", {31'b0, m_tvalid}, 32'd0);
        chk("abort_count", {27'b0, wr_count}, 32'd0);
        chk("abort_busy", {31'b0, busy}, 32'd0);
        chk("abort_tdata", m_tdata, 32'd0);
        model_q.delete();
        tick();
        rst_n = 1'b1;
        tick();
        chk("rerel_tready", {31'b0, s_tready}, 32'd1);

        // Write and rd_start together, from empty and with words already stored
        write_beat(32'h5555_AAAA, 4'hF, 1'b1);
        replay(1'b0, 0);
        write_beat($urandom, 4'hF, 1'b0);
        write_beat($urandom, 4'hF, 1'b0);
        write_beat(32'h0BAD_CAFE, 4'b1100, 1'b1);
        replay(1'b0, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
